fft_frame_loader: RTL and testbench

- Upstream neighbour of the 16-point combinational CORDIC/twiddle FFT core.
- Accepts a serial stream of complex Q1.15 samples over a valid/ready handshake and assembles them into POINT_FFT-sample frames in a ping-pong (two-bank) buffer.
- Presents each complete frame in parallel, natural order, held stable for the FFT core's data_i with a frame-level valid/ready handshake.
- Ping-pong banking lets streaming input continue while the previous frame is held for the downstream consumer.

---
 rtl/fft_frame_loader.sv | 94 +++++++++
 tb/tb_fft_frame_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_loader.sv
// Ping-pong frame assembler: collects a serial complex sample stream into
// POINT_FFT-sample frames and presents each frame in parallel to the FFT core.
module fft_frame_loader #(
  parameter int unsigned POINT_FFT_POW2 = 4,
  parameter int unsigned FRAC_BITS      = 15,
  localparam int unsigned POINT_FFT     = 1 << POINT_FFT_POW2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic signed [1:0][FRAC_BITS:0] sample_i,
  input  logic                           sample_valid_i,
  output logic                           sample_ready_o,
  input  logic                           flush_i,
  output logic signed [1:0][FRAC_BITS:0] frame_o [POINT_FFT],
  output logic                           frame_valid_o,
  input  logic                           frame_ready_i,
  output logic [POINT_FFT_POW2:0]        fill_count_o
);

  localparam int unsigned      PTR_W    = POINT_FFT_POW2;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(POINT_FFT - 1);

  logic signed [1:0][FRAC_BITS:0] bank [2][POINT_FFT];
  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic             wr_sel;
  logic             wr_sel_nxt;
  logic             rd_sel;
  logic             rd_sel_nxt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic             accept_c;
  logic             consume_c;

  assign sample_ready_o = !full[wr_sel];
  assign accept_c       = sample_valid_i && sample_ready_o && !flush_i;
  assign frame_valid_o  = full[rd_sel];
  assign consume_c      = frame_valid_o && frame_ready_i;
  assign fill_count_o   = (PTR_W + 1)'(wr_ptr);

  // Fill and drain never touch the same bank: the fill bank is empty by
  // construction and a consume only happens on a full read bank.
  always_comb begin
    full_nxt   = full;
    wr_sel_nxt = wr_sel;
    rd_sel_nxt = rd_sel;
    wr_ptr_nxt = wr_ptr;
    if (flush_i) begin
      wr_ptr_nxt = '0;
    end else if (accept_c) begin
      if (wr_ptr == LAST_IDX) begin
        full_nxt[wr_sel] = 1'b1;
        wr_sel_nxt       = !wr_sel;
        wr_ptr_nxt       = '0;
      end else begin
        wr_ptr_nxt = wr_ptr + PTR_W'(1);
      end
    end
    if (consume_c) begin
      full_nxt[rd_sel] = 1'b0;
      rd_sel_nxt       = !rd_sel;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      full   <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      wr_ptr <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < POINT_FFT; k++) begin
          bank[b][k] <= '0;
        end
      end
    end else begin
      full   <= full_nxt;
      wr_sel <= wr_sel_nxt;
      rd_sel <= rd_sel_nxt;
      wr_ptr <= wr_ptr_nxt;
      if (accept_c) begin
        bank[wr_sel][wr_ptr] <= sample_i;
      end
    end
  end

  // Output bank is straight register storage, no arithmetic on the path.
  always_comb begin
    for (int k = 0; k < POINT_FFT; k++) begin
      frame_o[k] = bank[rd_sel][k];
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed-vector and scoreboard bench for fft_frame_loader: streaming,
// backpressure, simultaneous complete/consume, flush, reset and random traffic.
module tb_fft_frame_loader;

  typedef logic signed [1:0][15:0] samp_t;

  typedef struct {
    logic vld;
    logic fl;
    logic rdy;
    int   re;
    int   im;
    logic e_sready;
    logic e_fvalid;
    int   e_fill;
  } vec_t;

  logic       clk;
  logic       rst_n;
  samp_t      sample;
  logic       valid;
  logic       sready;
  logic       flush;
  samp_t      frame [16];
  logic       fvalid;
  logic       fready;
  logic [4:0] fill;

  int n_vec = 0;
  int n_err = 0;
  vec_t vecs[$];

  fft_frame_loader dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .sample_i       (sample),
    .sample_valid_i (valid),
    .sample_ready_o (sready),
    .flush_i        (flush),
    .frame_o        (frame),
    .frame_valid_o  (fvalid),
    .frame_ready_i  (fready),
    .fill_count_o   (fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic samp_t mk(input int re, input int im);
    samp_t s;
    s[0] = 16'(re);
    s[1] = 16'(im);
    return s;
  endfunction

  task automatic add(input logic vld, input logic fl, input logic rdy, input int re, input int im,
                     input logic es, input logic ev, input int ef);
    vec_t v;
    v = '{vld, fl, rdy, re, im, es, ev, ef};
    vecs.push_back(v);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      valid  = vecs[i].vld;
      flush  = vecs[i].fl;
      fready = vecs[i].rdy;
      sample = mk(vecs[i].re, vecs[i].im);
      tick();
      chk($sformatf("row%0d_sready", i), 16'(sready), 16'(vecs[i].e_sready));
      chk($sformatf("row%0d_fvalid", i), 16'(fvalid), 16'(vecs[i].e_fvalid));
      chk($sformatf("row%0d_fill", i),   16'(fill),   16'(vecs[i].e_fill));
    end
    valid = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    samp_t q[$];
    samp_t prev [16];
    logic  hold;
    int    acc, frames, cyc, bad;

    // rows 0..16: basic stream; rows 17..40: flush scenario
    for (int k = 0; k < 16; k++) add(1'b1, 1'b0, 1'b1, k * 256, -k, 1'b1, k == 15, (k + 1) % 16);
    add(1'b0, 1'b0, 1'b1, 0, 0, 1'b1, 1'b0, 0);
    for (int k = 0; k < 7; k++) add(1'b1, 1'b0, 1'b0, k + 1, 0, 1'b1, 1'b0, k + 1);
    add(1'b1, 1'b1, 1'b0, 999, 999, 1'b1, 1'b0, 0);
    for (int k = 0; k < 16; k++) add(1'b1, 1'b0, 1'b0, 100 + k, -(100 + k), 1'b1, k == 15, (k + 1) % 16);

    rst_n = 1'b0; valid = 1'b0; flush = 1'b0; fready = 1'b0; sample = '0;
    tick();
    tick();
    chk("reset_sready", 16'(sready), 16'd1);
    chk("reset_fvalid", 16'(fvalid), 16'd0);
    chk("reset_fill",   16'(fill),   16'd0);
    chk("reset_frame0", frame[0][0], 16'd0);
    rst_n = 1'b1;

    // basic stream with ready held high
    run_rows(0, 15);
    chk("s1_f5_re",  frame[5][0],  16'd1280);
    chk("s1_f5_im",  frame[5][1],  16'(-5));
    chk("s1_f15_re", frame[15][0], 16'd3840);
    chk("s1_f0_im",  frame[0][1],  16'd0);
    run_rows(16, 16);

    // backpressure: both banks fill, then one handshake frees a bank
    fready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      valid = 1'b1;
      sample = mk(i, 500 + i);
      chk("bp_ready_pre", 16'(sready), 16'd1);
      tick();
    end
    chk("bp_sready_full", 16'(sready), 16'd0);
    chk("bp_fvalid",      16'(fvalid), 16'd1);
    chk("bp_fill",        16'(fill),   16'd0);
    chk("bp_f0_im",       frame[0][1], 16'd500);
    chk("bp_f15_re",      frame[15][0], 16'd15);
    sample = mk(32, 532);
    repeat (3) begin
      tick();
      chk("bp_hold_sready", 16'(sready), 16'd0);
      chk("bp_hold_f7",     frame[7][0], 16'd7);
      chk("bp_hold_fvalid", 16'(fvalid), 16'd1);
    end
    fready = 1'b1;
    tick();
    fready = 1'b0;
    chk("bp_f2_valid",  16'(fvalid), 16'd1);
    chk("bp_f2_f0",     frame[0][0], 16'd16);
    chk("bp_f2_f15",    frame[15][0], 16'd31);
    chk("bp_f2_sready", 16'(sready), 16'd1);
    chk("bp_f2_fill",   16'(fill),   16'd0);
    for (int i = 32; i < 48; i++) begin
      sample = mk(i, 500 + i);
      chk("bp_ready_f3", 16'(sready), 16'd1);
      tick();
      if (i == 39) chk("bp_fill8", 16'(fill), 16'd8);
    end
    valid = 1'b0;
    chk("bp_full_again", 16'(sready), 16'd0);
    fready = 1'b1;
    tick();
    fready = 1'b0;
    chk("bp_f3_s0", frame[0][0], 16'd32);
    chk("bp_f3_s7", frame[7][0], 16'd39);
    chk("bp_f3_s7i", frame[7][1], 16'd539);
    chk("bp_f3_s8", frame[8][0], 16'd40);
    fready = 1'b1;
    tick();
    fready = 1'b0;
    chk("bp_drained", 16'(fvalid), 16'd0);

    // last sample of frame B in the same cycle frame A is consumed
    valid = 1'b1;
    for (int k = 0; k < 16; k++) begin sample = mk(200 + k, -k); tick(); end
    for (int k = 0; k < 15; k++) begin sample = mk(300 + k, -k); tick(); end
    chk("sim_a_valid", 16'(fvalid), 16'd1);
    chk("sim_a_f0",    frame[0][0], 16'd200);
    chk("sim_fill15",  16'(fill),   16'd15);
    sample = mk(315, -15);
    fready = 1'b1;
    tick();
    valid = 1'b0;
    fready = 1'b0;
    chk("sim_b_valid",  16'(fvalid), 16'd1);
    chk("sim_b_f0",     frame[0][0], 16'd300);
    chk("sim_b_f15",    frame[15][0], 16'd315);
    chk("sim_b_sready", 16'(sready), 16'd1);
    chk("sim_b_fill",   16'(fill),   16'd0);
    fready = 1'b1;
    tick();
    fready = 1'b0;
    chk("sim_no_dup", 16'(fvalid), 16'd0);
    tick();
    chk("sim_no_dup2", 16'(fvalid), 16'd0);

    // flush discards a partial frame; the sample presented with it is dropped
    run_rows(17, 40);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("fl_slot%0d_re", k), frame[k][0], 16'(100 + k));
      chk($sformatf("fl_slot%0d_im", k), frame[k][1], 16'(-(100 + k)));
    end
    fready = 1'b1;
    tick();
    fready = 1'b0;
    chk("fl_consumed", 16'(fvalid), 16'd0);

    // reset with one bank full and nine samples pending
    valid = 1'b1;
    for (int k = 0; k < 25; k++) begin sample = mk(k + 1, k + 1); tick(); end
    valid = 1'b0;
    chk("rst_pre_fvalid", 16'(fvalid), 16'd1);
    chk("rst_pre_fill",   16'(fill),   16'd9);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_fvalid", 16'(fvalid), 16'd0);
    chk("rst_fill",   16'(fill),   16'd0);
    chk("rst_sready", 16'(sready), 16'd1);
    for (int k = 0; k < 16; k++) chk($sformatf("rst_slot%0d", k), frame[k][0] | frame[k][1], 16'd0);
    fready = 1'b1;
    tick();
    fready = 1'b0;
    chk("rst_no_frame", 16'(fvalid), 16'd0);

    // random valid/ready traffic against a sample scoreboard
    acc = 0; frames = 0; cyc = 0; hold = 1'b0;
    while ((acc < 1000 || fvalid) && cyc < 20000) begin
      valid  = (acc < 1000) && ($urandom_range(0, 3) != 0);
      sample = mk(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
      fready = (acc >= 1000) || ($urandom_range(0, 2) == 0);
      if (hold) begin
        bad = fvalid ? 0 : 1;
        for (int k = 0; k < 16; k++) if (frame[k] !== prev[k]) bad++;
        chk("rand_hold", 16'(bad), 16'd0);
      end
      if (valid && sready) begin
        q.push_back(sample);
        acc++;
      end
      if (fvalid && fready) begin
        bad = 0;
        for (int k = 0; k < 16; k++) begin
          if (q.size() == 0) bad++;
          else if (frame[k] !== q.pop_front()) bad++;
        end
        chk($sformatf("rand_frame%0d", frames), 16'(bad), 16'd0);
        frames++;
      end
      hold = fvalid && !fready;
      prev = frame;
      tick();
      cyc++;
    end
    valid = 1'b0;
    fready = 1'b0;
    chk("rand_budget",  16'(cyc < 20000), 16'd1);
    chk("rand_frames",  16'(frames),   16'd62);
    chk("rand_pending", 16'(q.size()), 16'd8);
    chk("rand_fill",    16'(fill),     16'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
